spi_init_sdc: RTL and testbench

SD-card SPI-mode power-up initializer. On a start pulse it clocks the card through the standard SPI-mode bring-up (≥74 dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop) and raises `o_done` once the card reports ready. It is the first stage of the SDC datapath, ahead of the block read/write engine, and owns the SPI pins until `o_done` rises.

---
 rtl/spi_init_sdc.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_init_sdc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_init_sdc.sv
// rtl/spi_init_sdc.sv - SD-card SPI-mode power-up initializer (dummy clocks, CMD0, CMD8, CMD55/ACMD41)
module spi_init_sdc #(
  parameter int CLK_DIV = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_miso,
  output logic o_mosi,
  output logic o_sclk,
  output logic o_cs,
  output logic o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_DONE
  } state_t;

  // Sub-phase of a command transaction: frame out, R1 poll, R7 read, CS-high trailer.
  typedef enum logic [1:0] {
    PH_CMD, PH_POLL, PH_R7, PH_TRAIL
  } phase_t;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       poll_cnt_q, poll_cnt_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       r1_q, r1_d;
  logic [7:0]       r7_q, r7_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;

  logic [7:0]       load_byte;
  logic             start_engine;
  logic             goto_cmd;
  logic             goto_dummy;
  state_t           next_cmd;

  logic [DIV_W-1:0] div_cnt_q;
  logic             sclk_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;

  logic             running;
  logic             half_end;
  logic             rise;
  logic             fall;
  logic             byte_end;

  // The byte engine only clocks while a bring-up sequence is in progress.
  assign running  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign half_end = running && (div_cnt_q == DIV_LAST);
  assign rise     = half_end && !sclk_q;
  assign fall     = half_end && sclk_q;
  // A byte ends on its 8th falling edge; the next byte starts on the same edge.
  assign byte_end = fall && (bit_cnt_q == 3'd7);

  assign o_mosi = tx_q[7];
  assign o_sclk = sclk_q;
  assign o_cs   = cs_q;
  assign o_done = done_q;

  function automatic logic [7:0] frame_byte(input state_t cmd, input logic [3:0] idx);
    logic [47:0] f;
    case (cmd)
      S_CMD0:   f = 48'h40_00_00_00_00_95;
      S_CMD8:   f = 48'h48_00_00_01_AA_87;
      S_CMD55:  f = 48'h77_00_00_00_00_65;
      S_ACMD41: f = 48'h69_40_00_00_00_77;
      default:  f = 48'hFF_FF_FF_FF_FF_FF;
    endcase
    case (idx)
      4'd0:    frame_byte = f[47:40];
      4'd1:    frame_byte = f[39:32];
      4'd2:    frame_byte = f[31:24];
      4'd3:    frame_byte = f[23:16];
      4'd4:    frame_byte = f[15:8];
      4'd5:    frame_byte = f[7:0];
      default: frame_byte = 8'hFF;
    endcase
  endfunction

  // Sequencing decisions, evaluated at byte boundaries (or on start in IDLE/DONE).
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    byte_cnt_d   = byte_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    tmo_d        = tmo_q;
    r1_d         = r1_q;
    r7_d         = r7_q;
    cs_d         = cs_q;
    done_d       = done_q;
    load_byte    = 8'hFF;
    start_engine = 1'b0;
    goto_cmd     = 1'b0;
    goto_dummy   = 1'b0;
    next_cmd     = S_CMD0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          start_engine = 1'b1;
          goto_dummy   = 1'b1;
          done_d       = 1'b0;
        end
      end
      S_DUMMY: begin
        if (byte_end) begin
          if (byte_cnt_q == 4'd9) begin
            goto_cmd = 1'b1;
            next_cmd = S_CMD0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        if (byte_end) begin
          case (phase_q)
            PH_CMD: begin
              if (byte_cnt_q == 4'd5) begin
                phase_d    = PH_POLL;
                poll_cnt_d = 4'd0;
              end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                load_byte  = frame_byte(state_q, byte_cnt_q + 4'd1);
              end
            end
            PH_POLL: begin
              if (!rx_q[7]) begin
                r1_d  = rx_q;
                tmo_d = 1'b0;
                if (state_q == S_CMD8) begin
                  phase_d    = PH_R7;
                  byte_cnt_d = 4'd0;
                end else begin
                  phase_d = PH_TRAIL;
                  cs_d    = 1'b1;
                end
              end else begin
                poll_cnt_d = poll_cnt_q + 4'd1;
                if (poll_cnt_q == 4'd7) begin
                  tmo_d   = 1'b1;
                  phase_d = PH_TRAIL;
                  cs_d    = 1'b1;
                end
              end
            end
            PH_R7: begin
              if (byte_cnt_q == 4'd3) begin
                r7_d    = rx_q;
                phase_d = PH_TRAIL;
                cs_d    = 1'b1;
              end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
              end
            end
            default: begin
              case (state_q)
                S_CMD0: begin
                  if (!tmo_q && r1_q == 8'h01) begin
                    goto_cmd = 1'b1;
                    next_cmd = S_CMD8;
                  end else begin
                    goto_dummy = 1'b1;
                  end
                end
                S_CMD8: begin
                  if (!tmo_q && ((r1_q == 8'h01 && r7_q == 8'hAA) || r1_q == 8'h05)) begin
                    goto_cmd = 1'b1;
                    next_cmd = S_CMD55;
                  end else begin
                    goto_dummy = 1'b1;
                  end
                end
                S_CMD55: begin
                  if (!tmo_q && (r1_q == 8'h01 || r1_q == 8'h00)) begin
                    goto_cmd = 1'b1;
                    next_cmd = S_ACMD41;
                  end else begin
                    goto_dummy = 1'b1;
                  end
                end
                default: begin
                  if (!tmo_q && r1_q == 8'h00) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                  end else if (!tmo_q && r1_q == 8'h01) begin
                    goto_cmd = 1'b1;
                    next_cmd = S_CMD55;
                  end else begin
                    goto_dummy = 1'b1;
                  end
                end
              endcase
            end
          endcase
        end
      end
    endcase

    if (goto_dummy) begin
      state_d    = S_DUMMY;
      byte_cnt_d = 4'd0;
      cs_d       = 1'b1;
    end
    if (goto_cmd) begin
      state_d    = next_cmd;
      phase_d    = PH_CMD;
      byte_cnt_d = 4'd0;
      cs_d       = 1'b0;
      load_byte  = frame_byte(next_cmd, 4'd0);
    end
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_CMD;
      byte_cnt_q <= 4'd0;
      poll_cnt_q <= 4'd0;
      tmo_q      <= 1'b0;
      r1_q       <= 8'h00;
      r7_q       <= 8'h00;
      cs_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      tmo_q      <= tmo_d;
      r1_q       <= r1_d;
      r7_q       <= r7_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
    end
  end

  // Mode-0 byte engine: SCLK half-period divider, MISO sampled on rise, MOSI shifted on fall.
  always_ff @(posedge i_clk) begin
    if (!i_rst || start_engine) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'hFF;
      rx_q      <= 8'h00;
    end else if (running) begin
      if (half_end) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
      if (rise) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], i_miso};
      end
      if (fall) begin
        sclk_q    <= 1'b0;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (byte_end) begin
          tx_q <= load_byte;
        end else begin
          tx_q <= {tx_q[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_init_sdc.sv
// tb/tb_spi_init_sdc.sv - directed bench for spi_init_sdc with a behavioural SD card
module tb_spi_init_sdc;

  localparam int DIV = 2;
  localparam int BYTE_CYC = 16 * DIV;
  localparam int IDEAL_BYTES = 10 + 8 + 12 + 8 + 8;

  logic clk;
  logic rst_n;
  logic start;
  logic miso;
  logic mosi;
  logic sclk;
  logic cs;
  logic done;

  int checks;
  int failures;

  // card model configuration (written by the stimulus block only)
  logic       card_en;
  logic [7:0] r8_r1;
  int         acmd_busy;

  // card model / monitor state (written by the monitor only)
  logic [7:0] byte_q[$];
  logic       bcs_q[$];
  int         cmd_q[$];
  logic [7:0] resp_q[$];
  int         rise_cnt;
  int         hi_rises;
  logic       seen_lo;
  logic       sclk_prev;
  int         bitn;
  logic [7:0] rxb;
  logic       rx_cs;
  logic [7:0] txb;
  int         cmd_len;
  logic [7:0] cmd_first;
  int         acmd_cnt;

  logic [7:0] exp_cmd0 [0:5];

  spi_init_sdc #(.CLK_DIV(DIV)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_start(start),
    .i_miso (miso),
    .o_mosi (mosi),
    .o_sclk (sclk),
    .o_cs   (cs),
    .o_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SD-card model: decodes commands from MOSI, answers on MISO changing on SCLK falls
  always @(negedge clk) begin
    if (!rst_n) begin
      byte_q.delete();
      bcs_q.delete();
      cmd_q.delete();
      resp_q.delete();
      rise_cnt  = 0;
      hi_rises  = 0;
      seen_lo   = 1'b0;
      sclk_prev = 1'b0;
      bitn      = 0;
      rxb       = 8'h00;
      rx_cs     = 1'b1;
      txb       = 8'hFF;
      cmd_len   = 0;
      cmd_first = 8'h00;
      acmd_cnt  = 0;
      miso      = 1'b1;
    end else begin
      if (sclk && !sclk_prev) begin
        rise_cnt++;
        if (!seen_lo) begin
          if (cs) hi_rises++;
          else seen_lo = 1'b1;
        end
        if (bitn == 0) rx_cs = cs;
        rxb = {rxb[6:0], mosi};
        bitn++;
        if (bitn == 8) begin
          byte_q.push_back(rxb);
          bcs_q.push_back(rx_cs);
          if (rx_cs) begin
            cmd_len = 0;
          end else begin
            if (cmd_len == 0) cmd_first = rxb;
            cmd_len++;
            if (cmd_len == 6) begin
              cmd_q.push_back(int'(cmd_first & 8'h3F));
              case (cmd_first & 8'h3F)
                8'd0:  resp_q.push_back(8'h01);
                8'd8: begin
                  resp_q.push_back(r8_r1);
                  if (r8_r1 == 8'h01) begin
                    resp_q.push_back(8'h00);
                    resp_q.push_back(8'h00);
                    resp_q.push_back(8'h01);
                    resp_q.push_back(8'hAA);
                  end
                end
                8'd55: resp_q.push_back(8'h01);
                8'd41: begin
                  if (acmd_cnt < acmd_busy) begin
                    acmd_cnt++;
                    resp_q.push_back(8'h01);
                  end else begin
                    resp_q.push_back(8'h00);
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end else if (!sclk && sclk_prev) begin
        if (bitn == 8) begin
          bitn = 0;
          if (resp_q.size() > 0) txb = resp_q.pop_front();
          else txb = 8'hFF;
        end else begin
          txb = {txb[6:0], 1'b1};
        end
        miso = card_en ? txb[7] : 1'b1;
      end
      sclk_prev = sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] cmd_sig4();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    if (cmd_q.size() >= 4)
      s = {cmd_q[0][7:0], cmd_q[1][7:0], cmd_q[2][7:0], cmd_q[3][7:0]};
    return s;
  endfunction

  initial begin
    int n;
    int bad;
    int cyc;
    int n55;
    int n41;
    int r0;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    card_en   = 1'b0;
    r8_r1     = 8'h01;
    acmd_busy = 0;
    exp_cmd0[0] = 8'h40; exp_cmd0[1] = 8'h00; exp_cmd0[2] = 8'h00;
    exp_cmd0[3] = 8'h00; exp_cmd0[4] = 8'h00; exp_cmd0[5] = 8'h95;

    // 1: reset values and idle without start
    do_reset();
    @(negedge clk);
    check("rst_cs",   {31'd0, cs},   32'd1);
    check("rst_mosi", {31'd0, mosi}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (500) @(negedge clk);
    check("idle_rises", rise_cnt, 0);
    check("idle_cs",    {31'd0, cs}, 32'd1);

    // 2: no card, MISO stuck high
    card_en = 1'b0;
    do_reset();
    pulse_start();
    n = 0;
    while (byte_q.size() < 36 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("nocard_bytes_seen", {31'd0, byte_q.size() >= 36}, 32'd1);
    check("nocard_dummy_rises", hi_rises, 80);
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (byte_q[i] !== 8'hFF || bcs_q[i] !== 1'b1) bad++;
    check("nocard_dummy_bytes", bad, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("nocard_cmd0_b%0d", i), {24'd0, byte_q[10 + i]}, {24'd0, exp_cmd0[i]});
      check($sformatf("nocard_cmd0_cs%0d", i), {31'd0, bcs_q[10 + i]}, 32'd0);
    end
    bad = 0;
    for (int i = 16; i < 24; i++)
      if (byte_q[i] !== 8'hFF || bcs_q[i] !== 1'b0) bad++;
    check("nocard_poll8", bad, 0);
    check("nocard_trailer_cs", {31'd0, bcs_q[24]}, 32'd1);
    check("nocard_trailer_ff", {24'd0, byte_q[24]}, 32'h0000_00FF);
    bad = 0;
    for (int i = 25; i < 35; i++)
      if (byte_q[i] !== 8'hFF || bcs_q[i] !== 1'b1) bad++;
    check("nocard_redummy", bad, 0);
    check("nocard_recmd0", {24'd0, byte_q[35]}, 32'h0000_0040);
    check("nocard_recmd0_cs", {31'd0, bcs_q[35]}, 32'd0);
    check("nocard_done", {31'd0, done}, 32'd0);

    // 3: ideal card, exact start-to-done latency
    card_en   = 1'b1;
    r8_r1     = 8'h01;
    acmd_busy = 0;
    do_reset();
    pulse_start();
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("ideal_latency", cyc, IDEAL_BYTES * BYTE_CYC);
    check("ideal_cmds", cmd_sig4(), 32'h00_08_37_29);
    check("ideal_ncmds", cmd_q.size(), 4);
    r0 = rise_cnt;
    repeat (200) @(negedge clk);
    check("ideal_done_sticky", {31'd0, done}, 32'd1);
    check("ideal_done_cs",     {31'd0, cs},   32'd1);
    check("ideal_done_mosi",   {31'd0, mosi}, 32'd1);
    check("ideal_done_sclk",   {31'd0, sclk}, 32'd0);
    check("ideal_done_quiet",  rise_cnt - r0, 0);

    // 4: ACMD41 busy three times
    acmd_busy = 3;
    do_reset();
    pulse_start();
    wait_done(8000, "busy_done");
    n55 = 0;
    n41 = 0;
    foreach (cmd_q[i]) begin
      if (cmd_q[i] == 55) n55++;
      if (cmd_q[i] == 41) n41++;
    end
    check("busy_n55", n55, 4);
    check("busy_n41", n41, 4);
    check("busy_ncmds", cmd_q.size(), 10);

    // 5: SDv1 card rejects CMD8
    acmd_busy = 0;
    r8_r1     = 8'h05;
    do_reset();
    pulse_start();
    wait_done(5000, "v1_done");
    check("v1_cmds", cmd_sig4(), 32'h00_08_37_29);
    check("v1_ncmds", cmd_q.size(), 4);

    // start in DONE clears done and restarts the dummy burst
    r0 = rise_cnt;
    pulse_start();
    @(negedge clk);
    check("restart_done_clr", {31'd0, done}, 32'd0);
    repeat (19) @(negedge clk);
    check("restart_rises", rise_cnt - r0, 5);

    // 6: reset in the middle of CMD8
    r8_r1 = 8'h01;
    do_reset();
    pulse_start();
    n = 0;
    while (cmd_q.size() < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_cmd8_reached", {31'd0, cmd_q.size() >= 2}, 32'd1);
    check("mid_cmd8_cs_low", {31'd0, cs}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs",   {31'd0, cs},   32'd1);
    check("midrst_mosi", {31'd0, mosi}, 32'd1);
    check("midrst_sclk", {31'd0, sclk}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_idle", rise_cnt, 0);
    pulse_start();
    wait_done(5000, "midrst_redone");
    check("midrst_dummy_rises", hi_rises, 80);
    check("midrst_cmds", cmd_sig4(), 32'h00_08_37_29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
